mul_pow2_seq: RTL
=================

// Module: mul_pow2_seq
// PURPOSE
//  Multi-cycle sequencer that multiplies an operand by 2^k by applying the single-step
//  doubling datapath (shift left 1, carry = old MSB) once per clock, k times.
//  Sits between the ALU operand/opcode decode and the result mux. Uses a valid/ready
//  handshake on both sides so the ALU control FSM can stall it.
//  Reports the final step's carry and a sticky overflow (any 1 shifted out of the MSB).
// PARAMETERS
//  WIDTH  8  operand/result width in bits
//  CNTW   3  shift-count width; k ranges 0..2^CNTW-1
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  clr        in   1      synchronous abort; returns to IDLE, discards the op in flight
//  in_valid   in   1      operand/count presented
//  in_ready   out  1      sequencer can accept (high only in IDLE)
//  x          in   WIDTH  operand
//  k          in   CNTW   number of doubling steps
//  out_valid  out  1      result valid (high only in DONE)
//  out_ready  in   1      consumer takes the result
//  p          out  WIDTH  result, x*2^k mod 2^WIDTH
//  c          out  1      carry of the final doubling step (0 when k==0)
//  ovf        out  1      sticky OR of all carries for this op
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, acc=0, cnt=0, c=0, ovf=0, out_valid=0.
//    in_ready reads 1 while rst is held, but no transfer occurs until rst deasserts.
//  - States: IDLE, RUN, DONE. in_ready=(state==IDLE); out_valid=(state==DONE).
//  - p, c and ovf are driven directly from registers. They are meaningful only while
//    out_valid=1 and are held stable in DONE.
//  - IDLE: when in_valid & in_ready, load acc<=x, cnt<=k, c<=0, ovf<=0.
//    Next state is DONE if k==0, else RUN.
//  - RUN: each edge, acc<=acc<<1, c<=acc[WIDTH-1], ovf<=ovf|acc[WIDTH-1], cnt<=cnt-1.
//    When cnt==1 (the last step), next state is DONE.
//  - Latency: out_valid rises exactly k+1 clock edges after the accept edge.
//  - DONE: hold all outputs until out_valid & out_ready, then go to IDLE.
//    No new accept is possible on that same edge.
//  - Throughput: one op per k+2 cycles with out_ready tied high.
//  - k=2^CNTW-1 with WIDTH=8 shifts 7 times. Only the original bit 0 can survive.
//  - clr=1 in any state: next edge goes to IDLE, acc/cnt/c/ovf cleared, and no accept
//    occurs. clr beats a simultaneous in_valid or out_ready.
//  - in_valid while in RUN or DONE is ignored; the upstream must hold it.
//  - rst mid-RUN: immediate return to the reset values. The op is lost; no partial result.
//  - Arithmetic is unsigned, truncated to WIDTH bits. No sign handling.
// TESTING
//  1. x=0x03, k=2 -> out_valid 3 edges after accept; p=0x0C, c=0, ovf=0.
//  2. x=0x81, k=1 -> p=0x02, c=1, ovf=1.
//  3. x=0x40, k=3 -> p=0x00, c=0, ovf=1 (sticky overflow differs from last carry).
//  4. x=0xA5, k=0 -> out_valid after 1 edge; p=0xA5, c=0, ovf=0.
//     Then hold out_ready=0 for 5 cycles: outputs stable, in_ready=0,
//     and a new in_valid is not accepted.
//  5. x=0x01, k=7; pulse rst at the 4th RUN cycle -> outputs zero immediately,
//     in_ready=1 after release. Repeat with clr instead -> IDLE on the next edge,
//     ovf=0, no out_valid.
//  6. Back-to-back x=0x11,k=1 then x=0xF0,k=4 with in_valid/out_ready held high
//     -> p=0x22 then p=0x00 with ovf=1; second accept occurs the cycle after the
//     first result is consumed.

Source files
------------

// File: rtl/mul_pow2_seq_if.sv
// Operand/result handshake between the ALU control FSM (master) and the doubling sequencer (slave).
// clr rides with the request side because the same controller that issues ops also aborts them.
interface mul_pow2_seq_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 3
);
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [CNTW-1:0]  k;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] p;
  logic             c;
  logic             ovf;

  modport master (
    output clr, in_valid, x, k, out_ready,
    input  in_ready, out_valid, p, c, ovf
  );

  modport slave (
    input  clr, in_valid, x, k, out_ready,
    output in_ready, out_valid, p, c, ovf
  );
endinterface

// File: rtl/mul_pow2_seq.sv
// Multiplies x by 2^k with one doubling step per clock; result valid k+1 edges after accept.
// Accepts only in IDLE and holds the result in DONE until the consumer takes it.
module mul_pow2_seq #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 3
) (
  input  logic           clk,
  input  logic           rst,
  mul_pow2_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [CNTW-1:0]  cnt;
  logic             carry;
  logic             ovf_sticky;

  logic             accept;
  logic             consume;
  logic             last_step;
  logic             zero_k;

  assign accept    = bus.in_valid  & (state == IDLE);
  assign consume   = bus.out_ready & (state == DONE);
  assign last_step = (cnt == CNTW'(1));
  assign zero_k    = (bus.k == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // clr outranks every handshake, so it is tested before the per-state transitions.
  always_comb begin
    state_nxt = state;
    if (bus.clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (accept)    state_nxt = zero_k ? DONE : RUN;
        RUN:  if (last_step) state_nxt = DONE;
        DONE: if (consume)   state_nxt = IDLE;
        default:             state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (bus.clr) begin
      acc        <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc        <= bus.x;
            cnt        <= bus.k;
            carry      <= 1'b0;
            ovf_sticky <= 1'b0;
          end
        end
        RUN: begin
          acc        <= {acc[WIDTH-2:0], 1'b0};
          carry      <= acc[WIDTH-1];
          ovf_sticky <= ovf_sticky | acc[WIDTH-1];
          cnt        <= cnt - CNTW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.p   = acc;
  assign bus.c   = carry;
  assign bus.ovf = ovf_sticky;

endmodule
